// File: rtl/fetch_requester_if.sv
// -----------------------------------------------------------------------------
// fetch_requester_if
//   32-bit mem_itf read/write bus between an initiator (master) and a memory
//   (slave). Requests are single-cycle mask pulses; responses are single-cycle
//   mem_resp pulses that return in request order.
//
//   mem_addr   master->slave  32  word-aligned request address
//   mem_rmask  master->slave  4   byte read enables, nonzero only on a request cycle
//   mem_wmask  master->slave  4   byte write enables
//   mem_wdata  master->slave  32  write data
//   mem_rdata  slave->master  32  read data, valid while mem_resp=1
//   mem_resp   slave->master  1   one-cycle response pulse
// -----------------------------------------------------------------------------
interface fetch_requester_if;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_addr,
    output mem_rmask,
    output mem_wmask,
    output mem_wdata,
    input  mem_rdata,
    input  mem_resp
  );

  modport slave (
    input  mem_addr,
    input  mem_rmask,
    input  mem_wmask,
    input  mem_wdata,
    output mem_rdata,
    output mem_resp
  );
endinterface : fetch_requester_if

// File: rtl/fetch_requester.sv
// -----------------------------------------------------------------------------
// fetch_requester
//   CPU-side instruction fetch requester. Issues sequential word-aligned read
//   requests from an internal PC (at most one outstanding), collects in-order
//   responses into a DEPTH-entry FIFO of {pc, inst} and hands them to decode
//   over a valid/ready channel. A redirect flushes the FIFO, restarts fetch at
//   a new PC and drops whatever response is still in flight.
//
// Parameters
//   RESET_PC        PC fetched first after reset
//   DEPTH           FIFO entries (power of 2, >= 2)
//
// Ports
//   clk             clock
//   rst             synchronous active-high reset
//   redirect_valid  restart fetch at redirect_pc this cycle
//   redirect_pc     new PC; bits [1:0] ignored
//   out_valid       FIFO head valid
//   out_ready       consumer accepts head
//   out_pc          PC of head entry
//   out_inst        instruction word of head entry
//   bus             mem_itf master: request address/masks out, rdata/resp in
// -----------------------------------------------------------------------------
module fetch_requester #(
  parameter logic [31:0] RESET_PC = 32'h1ECE_B000,
  parameter int          DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_pc,
  output logic [31:0]               out_inst,
  fetch_requester_if.master         bus
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  // IDLE:    no request outstanding
  // WAIT:    one request outstanding whose data will be kept
  // DISCARD: one request outstanding whose data belongs to a flushed stream
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state;
  state_t          state_n;

  // pc is the address of the outstanding request in WAIT, and the address of
  // the next request to issue in IDLE/DISCARD.
  logic [31:0]     pc;
  logic [AW:0]     count;
  logic [AW:0]     count_n;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  logic [31:0]     fifo_pc   [DEPTH];
  logic [31:0]     fifo_inst [DEPTH];

  logic            push;
  logic            pop;
  logic            space;
  logic            issue;
  logic [31:0]     req_addr;

  // Low address bits of a redirect target are dropped on purpose.
  logic [1:0]      unused_redirect_bits;
  assign unused_redirect_bits = redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // Handshake terms shared by the FSM and the FIFO
  // ---------------------------------------------------------------------------
  // Head is hidden during reset so the consumer never sees pre-reset contents.
  assign out_valid = (count != '0) && !rst;
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign push      = (state == WAIT) && bus.mem_resp && !redirect_valid;
  assign count_n   = count + (AW+1)'(push) - (AW+1)'(pop);
  // Room for one more entry after this cycle's push/pop; a new request is only
  // issued when its response is guaranteed a slot.
  assign space     = count_n < DEPTH_C;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: state_n gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (!redirect_valid && space) state_n = WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          // A response arriving with the redirect is simply dropped; without
          // one, the owed response must still be absorbed.
          state_n = bus.mem_resp ? IDLE : DISCARD;
        end else if (bus.mem_resp) begin
          state_n = space ? WAIT : IDLE;
        end
      end
      DISCARD: begin
        // The owed response retires the discard even if a second redirect
        // lands on the same cycle; nothing else is in flight after it.
        if (bus.mem_resp) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (request generation)
  // ---------------------------------------------------------------------------
  always_comb begin
    issue    = 1'b0;
    req_addr = pc;
    unique case (state)
      IDLE: begin
        issue = !redirect_valid && space;
      end
      WAIT: begin
        // Back-to-back issue on the response cycle targets the word after the
        // one being returned, giving one instruction per cycle on 1-cycle memory.
        issue    = push && space;
        req_addr = pc + 32'd4;
      end
      default: ;
    endcase
    if (rst) issue = 1'b0;
  end

  assign bus.mem_addr  = req_addr;
  assign bus.mem_rmask = issue ? 4'hF : 4'h0;
  assign bus.mem_wmask = 4'h0;
  assign bus.mem_wdata = 32'h0;

  // ---------------------------------------------------------------------------
  // PC, occupancy and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count_n;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        pc     <= pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: storage is deliberately not reset; count alone decides which
  // entries are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_pc[wr_ptr]   <= pc;
      fifo_inst[wr_ptr] <= bus.mem_rdata;
    end
  end

  assign out_pc   = fifo_pc[rd_ptr];
  assign out_inst = fifo_inst[rd_ptr];

  // A response with nothing outstanding is a memory-side protocol error; the
  // FSM ignores it, this flags it.
  resp_in_idle: assert property (@(posedge clk) disable iff (rst)
    !(state == IDLE && bus.mem_resp));

endmodule : fetch_requester

// File: tb/tb_fetch_requester.sv
module tb_fetch_requester;

  localparam logic [31:0] A = 32'h1ECE_B000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  fetch_requester_if bus ();

  fetch_requester #(.RESET_PC(A), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int lat_min  = 1;
  int lat_max  = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Magic memory contents: word at RESET_PC+4k holds 0x1000_0000+k.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + ((addr - A) >> 2);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_timeout"}, 32'(ok), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Memory: reset by the same rst, one request accepted per cycle, response
  // after lat_min..lat_max cycles.
  // ---------------------------------------------------------------------------
  initial begin : memory
    logic        req_s, resp_s, rst_s, pend;
    logic [31:0] addr_s, paddr;
    int          cnt;
    pend = 1'b0; paddr = '0; cnt = 0;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      rst_s  = rst;
      req_s  = (bus.mem_rmask == 4'hF);
      addr_s = bus.mem_addr;
      resp_s = bus.mem_resp;
      if (!rst_s && req_s) check("one_outstanding", 32'(pend && !resp_s), 32'd0);
      @(posedge clk);
      #1;
      bus.mem_resp = 1'b0;
      if (rst_s) begin
        pend = 1'b0;
      end else begin
        if (resp_s) pend = 1'b0;
        if (req_s) begin
          pend  = 1'b1;
          paddr = addr_s;
          cnt   = $urandom_range(lat_max, lat_min);
        end else if (pend) begin
          cnt--;
        end
        if (pend && cnt == 1) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = mem_word(paddr);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: the accepted stream after reset/redirect to P is exactly
  // P, P+4, P+8, ... each paired with its memory word.
  // ---------------------------------------------------------------------------
  initial begin : scoreboard
    logic [31:0] exp_pc;
    logic        after_redir;
    exp_pc = A;
    after_redir = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rmask_in_rst", 32'(bus.mem_rmask), 32'd0);
        check("valid_in_rst", 32'(out_valid), 32'd0);
        exp_pc = A;
        after_redir = 1'b0;
        continue;
      end
      if (bus.mem_rmask == 4'hF) check("addr_align", 32'(bus.mem_addr[1:0]), 32'd0);
      if (after_redir) check("valid_after_redirect", 32'(out_valid), 32'd0);
      after_redir = 1'b0;
      if (redirect_valid) begin
        check("rmask_on_redirect", 32'(bus.mem_rmask), 32'd0);
        exp_pc = {redirect_pc[31:2], 2'b00};
        after_redir = 1'b1;
      end else if (out_valid && out_ready) begin
        check("stream_pc", out_pc, exp_pc);
        check("stream_inst", out_inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Directed table: one record per cycle after reset release, 1-cycle memory.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic [3:0]  rmask;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  function automatic vec_t v(input logic redir, input logic [31:0] rpc, input logic ready,
                             input logic [3:0] rmask, input logic [31:0] addr,
                             input logic valid, input logic [31:0] pc, input logic [31:0] inst);
    vec_t r;
    r.redir = redir; r.rpc = rpc; r.ready = ready; r.rmask = rmask;
    r.addr = addr; r.valid = valid; r.pc = pc; r.inst = inst;
    return r;
  endfunction

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin : main
    logic ok;

    // Fill with out_ready=0 (exactly four requests), then drain, redirect on a
    // response cycle, and restart at the redirect target.
    vecs[0]  = v(0, 0, 0, 4'hF, A,          0, 0,       0);
    vecs[1]  = v(0, 0, 0, 4'hF, A + 32'h4,  0, 0,       0);
    vecs[2]  = v(0, 0, 0, 4'hF, A + 32'h8,  1, A,       32'h1000_0000);
    vecs[3]  = v(0, 0, 0, 4'hF, A + 32'hC,  1, A,       32'h1000_0000);
    vecs[4]  = v(0, 0, 0, 4'h0, 0,          1, A,       32'h1000_0000);
    vecs[5]  = v(0, 0, 0, 4'h0, 0,          1, A,       32'h1000_0000);
    vecs[6]  = v(0, 0, 1, 4'hF, A + 32'h10, 1, A,       32'h1000_0000);
    vecs[7]  = v(0, 0, 1, 4'hF, A + 32'h14, 1, A + 4,   32'h1000_0001);
    vecs[8]  = v(0, 0, 1, 4'hF, A + 32'h18, 1, A + 8,   32'h1000_0002);
    vecs[9]  = v(1, 32'h0000_1002, 1, 4'h0, 0, 1, A + 12, 32'h1000_0003);
    vecs[10] = v(0, 0, 1, 4'hF, 32'h1000,   0, 0,       0);
    vecs[11] = v(0, 0, 1, 4'hF, 32'h1004,   0, 0,       0);
    vecs[12] = v(0, 0, 1, 4'hF, 32'h1008,   1, 32'h1000, mem_word(32'h1000));

    lat_min = 1; lat_max = 1;
    do_reset();
    check("reset_wmask", 32'(bus.mem_wmask), 32'd0);
    check("reset_wdata", bus.mem_wdata, 32'd0);
    for (int i = 0; i < NV; i++) begin
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].ready;
      @(negedge clk);
      check($sformatf("t%0d_rmask", i), 32'(bus.mem_rmask), 32'(vecs[i].rmask));
      if (vecs[i].rmask == 4'hF) check($sformatf("t%0d_addr", i), bus.mem_addr, vecs[i].addr);
      check($sformatf("t%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("t%0d_pc", i), out_pc, vecs[i].pc);
        check($sformatf("t%0d_inst", i), out_inst, vecs[i].inst);
      end
      step();
    end
    redirect_valid = 1'b0;

    // Redirect while waiting with no response: the stale word is absorbed and
    // the next entry comes from the aligned redirect target.
    lat_min = 3; lat_max = 3;
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    check("disc_first_req", 32'(bus.mem_rmask), 32'hF);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1002;
    @(negedge clk);
    check("disc_no_req", 32'(bus.mem_rmask), 32'd0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("disc_hold_req", 32'(bus.mem_rmask), 32'd0);
    wait_valid("disc", ok);
    if (ok) begin
      check("disc_pc", out_pc, 32'h0000_1000);
      check("disc_inst", out_inst, mem_word(32'h0000_1000));
    end
    step();

    // Reset in the middle of a wait: refetch restarts at RESET_PC.
    do_reset();
    out_ready = 1'b1;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_rmask", 32'(bus.mem_rmask), 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_restart_rmask", 32'(bus.mem_rmask), 32'hF);
    check("rst_restart_addr", bus.mem_addr, A);
    wait_valid("rst_restart", ok);
    if (ok) begin
      check("rst_restart_pc", out_pc, A);
      check("rst_restart_inst", out_inst, 32'h1000_0000);
    end
    step();

    // Randomized traffic against the stream model.
    lat_min = 1; lat_max = 4;
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(199, 0) == 0);
      redirect_valid = !rst && ($urandom_range(24, 0) == 0);
      redirect_pc    = $urandom;
      out_ready      = ($urandom_range(3, 0) != 0);
      step();
    end
    rst            = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    repeat (10) step();
    check("liveness", 32'(n_acc > 300), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fetch_requester
